// File: rtl/scaler_measure_if.sv
// scaler_measure_if: video timing, requested size, ratio outputs and interpolator handshake.
interface scaler_measure_if #(parameter int bitwidth = 10);
    logic                pix_en, hblank, vblank;
    logic [bitwidth-1:0] out_width, out_height;
    logic [bitwidth-1:0] num_h, num_v, den_h, den_v;
    logic                newfraction_h, newfraction_v;
    logic                ready_h, ready_v, valid;
    modport master (
        output pix_en, hblank, vblank, out_width, out_height, ready_h, ready_v,
        input  num_h, num_v, den_h, den_v, newfraction_h, newfraction_v, valid
    );
    modport slave (
        input  pix_en, hblank, vblank, out_width, out_height, ready_h, ready_v,
        output num_h, num_v, den_h, den_v, newfraction_h, newfraction_v, valid
    );
endinterface

// File: rtl/scaler_measure.sv
// scaler_measure: measures input frame size and hands a stable in/out ratio to the interpolators.
module scaler_measure #(parameter int bitwidth = 10) (
    input logic clk,
    input logic reset_n,
    scaler_measure_if.slave bus
);
    typedef enum logic [1:0] {MEASURE, ISSUE, WAIT, LOCKED} state_t;
    localparam logic [bitwidth-1:0] ALL1 = '1;
    state_t              state;
    logic [bitwidth-1:0] hcnt, vcnt, wmax, prev_w, prev_h, cand_w, cand_h;
    logic [bitwidth-1:0] num_h, num_v, den_h, den_v;
    logic                hb_d, vb_d, done_h, done_v, valid_q;
    logic [1:0]          wait_cnt;
    logic                active, line_end, frame_end, stable, differ;
    assign active    = bus.pix_en & ~bus.hblank & ~bus.vblank;
    assign line_end  = bus.pix_en & bus.hblank & ~hb_d & (hcnt != '0);
    assign frame_end = bus.pix_en & bus.vblank & ~vb_d;
    // candidates already fold in a line ending in the same cycle as the frame
    assign cand_w    = (line_end && hcnt > wmax) ? hcnt : wmax;
    assign cand_h    = (line_end && vcnt != ALL1) ? vcnt + 1'b1 : vcnt;
    assign stable    = frame_end & (cand_w != '0) & (cand_h != '0) & (cand_w == prev_w) & (cand_h == prev_h);
    assign differ    = {cand_w, cand_h, bus.out_width, bus.out_height} != {den_h, den_v, num_h, num_v};
    assign bus.num_h = num_h;
    assign bus.num_v = num_v;
    assign bus.den_h = den_h;
    assign bus.den_v = den_v;
    assign bus.valid = valid_q;
    assign bus.newfraction_h = (state == ISSUE) & bus.pix_en;
    assign bus.newfraction_v = (state == ISSUE) & bus.pix_en;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= MEASURE;
            hcnt     <= '0;
            vcnt     <= '0;
            wmax     <= '0;
            prev_w   <= '0;
            prev_h   <= '0;
            num_h    <= '0;
            num_v    <= '0;
            den_h    <= '0;
            den_v    <= '0;
            hb_d     <= 1'b0;
            vb_d     <= 1'b0;
            done_h   <= 1'b0;
            done_v   <= 1'b0;
            valid_q  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (bus.pix_en) begin
                hb_d <= bus.hblank;
                vb_d <= bus.vblank;
                if (frame_end) begin
                    hcnt   <= '0;
                    vcnt   <= '0;
                    wmax   <= '0;
                    prev_w <= cand_w;
                    prev_h <= cand_h;
                end else if (line_end) begin
                    hcnt <= '0;
                    vcnt <= cand_h;
                    wmax <= cand_w;
                end else if (active && hcnt != ALL1) hcnt <= hcnt + 1'b1;
            end
            case (state)
                MEASURE, LOCKED: if (stable && differ) begin
                    state   <= ISSUE;
                    den_h   <= cand_w;
                    den_v   <= cand_h;
                    num_h   <= bus.out_width;
                    num_v   <= bus.out_height;
                    valid_q <= 1'b0;
                end
                ISSUE: if (bus.pix_en) begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                    done_h   <= 1'b0;
                    done_v   <= 1'b0;
                end
                WAIT: if (done_h && done_v) begin
                    state   <= LOCKED;
                    valid_q <= 1'b1;
                end else if (wait_cnt != 2'd2) wait_cnt <= wait_cnt + 1'b1;
                else begin
                    done_h <= done_h | bus.ready_h;
                    done_v <= done_v | bus.ready_v;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_scaler_measure.sv
// tb_scaler_measure: directed frames with a model interpolator that answers 5 cycles after each request.
module tb_scaler_measure;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   passed = 0, total = 0, pulses = 0, nf_skew = 0, tmr = 0;
    bit   hold_v = 1'b0, vpend = 1'b0;
    always #5 clk = ~clk;
    scaler_measure_if #(.bitwidth(10)) bus ();
    scaler_measure #(.bitwidth(10)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else passed++;
    endtask
    task automatic drive(input logic p, input logic hb, input logic vb);
        bus.pix_en = p;
        bus.hblank = hb;
        bus.vblank = vb;
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        repeat (n) drive(1, 1, 1);
    endtask
    // first line carries the width, the rest are 1 pixel; last line ends with hblank and vblank together
    task automatic frame(input int w, input int h, input bit pause = 1'b0);
        for (int l = 0; l < h; l++) begin
            for (int p = 0; p < ((l == 0) ? w : 1); p++) begin
                drive(1, 0, 0);
                if (pause && l == 0 && p == 5) repeat (3) drive(0, 1, 1);
            end
            if (l < h - 1) drive(1, 1, 0);
        end
        idle(2);
    endtask
    task automatic wait_valid();
        int t = 0;
        while (bus.valid !== 1'b1 && t < 100) begin
            idle(1);
            t++;
        end
        chk("valid_rise", bus.valid, 1);
    endtask
    initial begin
        bus.ready_h = 1'b0;
        bus.ready_v = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.newfraction_h) begin
                pulses++;
                if (bus.newfraction_v !== 1'b1) nf_skew++;
                bus.ready_h = 1'b0;
                bus.ready_v = 1'b0;
                vpend = 1'b0;
                tmr = 5;
            end else begin
                if (bus.newfraction_v) nf_skew++;
                if (tmr > 0) begin
                    tmr--;
                    if (tmr == 0) begin
                        bus.ready_h = 1'b1;
                        vpend = 1'b1;
                    end
                end
                if (vpend && !hold_v) begin
                    bus.ready_v = 1'b1;
                    vpend = 1'b0;
                end
            end
        end
    end
    initial begin
        bus.pix_en = 1'b0;
        bus.hblank = 1'b1;
        bus.vblank = 1'b1;
        bus.out_width = 10'd640;
        bus.out_height = 10'd480;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus.valid, 0);
        chk("rst_den_h", bus.den_h, 0);
        chk("rst_num_h", bus.num_h, 0);
        chk("rst_nf", bus.newfraction_h, 0);
        reset_n = 1'b1;
        idle(4);
        chk("post_rst_pulses", pulses, 0);
        frame(320, 240);
        chk("f1_no_pulse", pulses, 0);
        frame(320, 240);
        chk("f2_pulse", pulses, 1);
        chk("f2_valid_low", bus.valid, 0);
        wait_valid();
        chk("f2_den_h", bus.den_h, 320);
        chk("f2_den_v", bus.den_v, 240);
        chk("f2_num_h", bus.num_h, 640);
        chk("f2_num_v", bus.num_v, 480);
        frame(320, 240, 1'b1);
        idle(20);
        chk("f3_no_pulse", pulses, 1);
        chk("f3_valid", bus.valid, 1);
        frame(321, 240);
        chk("w321_first", pulses, 1);
        frame(321, 240);
        chk("w321_second", pulses, 2);
        wait_valid();
        chk("w321_den_h", bus.den_h, 321);
        hold_v = 1'b1;
        bus.out_width = 10'd800;
        bus.out_height = 10'd600;
        frame(321, 240);
        chk("out_change_pulse", pulses, 3);
        frame(256, 192);
        frame(256, 192);
        idle(10);
        chk("wait_no_issue", pulses, 3);
        chk("wait_valid_low", bus.valid, 0);
        hold_v = 1'b0;
        wait_valid();
        chk("held_den_h", bus.den_h, 321);
        chk("held_num_h", bus.num_h, 800);
        frame(256, 192);
        chk("mode_pulse", pulses, 4);
        wait_valid();
        chk("mode_den_h", bus.den_h, 256);
        chk("mode_den_v", bus.den_v, 192);
        hold_v = 1'b1;
        bus.out_width = 10'd1000;
        bus.out_height = 10'd700;
        frame(256, 192);
        chk("pre_rst_pulse", pulses, 5);
        chk("pre_rst_num_h", bus.num_h, 1000);
        #2 reset_n = 1'b0;
        #1;
        chk("async_valid", bus.valid, 0);
        chk("async_den_h", bus.den_h, 0);
        chk("async_num_h", bus.num_h, 0);
        chk("async_num_v", bus.num_v, 0);
        idle(2);
        reset_n = 1'b1;
        hold_v = 1'b0;
        frame(256, 192);
        chk("rst_f1_no_pulse", pulses, 5);
        frame(256, 192);
        chk("rst_f2_pulse", pulses, 6);
        wait_valid();
        chk("rst_den_h2", bus.den_h, 256);
        chk("rst_num_v2", bus.num_v, 700);
        frame(1500, 2);
        frame(1500, 2);
        chk("sat_pulse", pulses, 7);
        wait_valid();
        chk("sat_den_h", bus.den_h, 1023);
        chk("sat_den_v", bus.den_v, 2);
        chk("nf_pair", nf_skew, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
